// File: rtl/program_rom_ctrl.sv
// Boot-loadable program store: written over the load port while in BOOT, then locked
// and served through a fixed-latency fetch pipeline with out-of-range fault reporting.
module program_rom_ctrl #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DEPTH        = 128,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_fault,
    output logic                  locked,
    output logic                  load_err,
    output logic [DATA_WIDTH-1:0] load_sum
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAT   = (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 3) ? 3 : READ_LATENCY);
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable in the bound.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

    function automatic mem_t default_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       img[i] = DATA_WIDTH'(8'h86);
                1:       img[i] = DATA_WIDTH'(8'hAA);
                2:       img[i] = DATA_WIDTH'(8'h96);
                3:       img[i] = DATA_WIDTH'(8'hE0);
                4:       img[i] = DATA_WIDTH'(8'h20);
                default: img[i] = '0;
            endcase
        end
        return img;
    endfunction

    // Contents survive reset; only the power-up image is preset.
    mem_t mem_q = default_image();

    state_t                state_q, state_d;
    logic                  load_err_q, load_err_d;
    logic [DATA_WIDTH-1:0] load_sum_q, load_sum_d;

    logic                  pipe_vld_q [LAT];
    logic                  pipe_vld_d [LAT];
    logic                  pipe_flt_q [LAT];
    logic                  pipe_flt_d [LAT];
    logic [DATA_WIDTH-1:0] pipe_dat_q [LAT];
    logic [DATA_WIDTH-1:0] pipe_dat_d [LAT];

    logic                  load_in_range;
    logic                  rd_in_range;
    logic                  mem_we;
    logic                  accept;
    logic [IDX_W-1:0]      load_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign load_in_range = ({1'b0, load_addr} < DEPTH_EXT);
    assign rd_in_range   = ({1'b0, rd_addr} < DEPTH_EXT);
    assign load_idx      = load_addr[IDX_W-1:0];
    assign rd_idx        = rd_addr[IDX_W-1:0];
    assign rd_word       = mem_q[rd_idx];

    assign locked   = (state_q == RUN);
    assign rd_ready = locked;
    assign accept   = rd_req & rd_ready;
    assign mem_we   = (state_q == BOOT) & load_we & load_in_range;

    always_comb begin
        state_d    = state_q;
        load_err_d = load_err_q;
        load_sum_d = load_sum_q;

        case (state_q)
            BOOT: begin
                if (load_we) begin
                    if (load_in_range) begin
                        load_sum_d = load_sum_q + load_data;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                if (load_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load_we) begin
                    load_err_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            load_err_q <= 1'b0;
            load_sum_q <= '0;
        end else begin
            state_q    <= state_d;
            load_err_q <= load_err_d;
            load_sum_q <= load_sum_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[load_idx] <= load_data;
        end
    end

    // Each stage's data only moves with a valid token, so the last stage holds the last fetch.
    always_comb begin
        for (int i = 0; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i];
            pipe_flt_d[i] = pipe_flt_q[i];
            pipe_dat_d[i] = pipe_dat_q[i];
        end

        pipe_vld_d[0] = accept;
        pipe_flt_d[0] = accept & ~rd_in_range;
        if (accept) begin
            pipe_dat_d[0] = rd_in_range ? rd_word : FILL_VALUE;
        end

        for (int i = 1; i < LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_flt_d[i] = pipe_flt_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_dat_d[i] = pipe_dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_flt_q[i] <= 1'b0;
                pipe_dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_d[i];
                pipe_flt_q[i] <= pipe_flt_d[i];
                pipe_dat_q[i] <= pipe_dat_d[i];
            end
        end
    end

    assign rd_valid = pipe_vld_q[LAT-1];
    assign rd_fault = pipe_flt_q[LAT-1];
    assign rd_data  = pipe_dat_q[LAT-1];
    assign load_err = load_err_q;
    assign load_sum = load_sum_q;

endmodule

// File: tb/tb_program_rom_ctrl.sv
// Scoreboard bench for program_rom_ctrl: one instance at read latency 1 and one at 3 share stimulus.
module tb_program_rom_ctrl;

    logic       clock;
    logic       reset;
    logic       load_we;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic       load_done;
    logic       rd_req;
    logic [7:0] rd_addr;

    logic       rd_ready1, rd_valid1, rd_fault1, locked1, load_err1;
    logic [7:0] rd_data1, load_sum1;
    logic       rd_ready3, rd_valid3, rd_fault3, locked3, load_err3;
    logic [7:0] rd_data3, load_sum3;

    program_rom_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(128), .READ_LATENCY(1), .FILL_VALUE(8'h00)) dut1 (
        .clock(clock), .reset(reset),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready1), .rd_valid(rd_valid1),
        .rd_data(rd_data1), .rd_fault(rd_fault1), .locked(locked1), .load_err(load_err1),
        .load_sum(load_sum1)
    );

    program_rom_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(128), .READ_LATENCY(3), .FILL_VALUE(8'h00)) dut3 (
        .clock(clock), .reset(reset),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready3), .rd_valid(rd_valid3),
        .rd_data(rd_data3), .rd_fault(rd_fault3), .locked(locked3), .load_err(load_err3),
        .load_sum(load_sum3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       fault;
    } exp_t;

    exp_t       sb1[$];
    exp_t       sb3[$];
    exp_t       e1, e3;
    logic [7:0] mem_m [256];
    bit         locked_m, err_m;
    logic [7:0] sum_m;
    logic [7:0] last1, last3;
    int         edge_cnt;
    int         n_checks;
    int         n_fail;

    // Comparison primitive; every scoreboard and directed check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    task automatic modelReset();
        locked_m = 1'b0;
        err_m    = 1'b0;
        sum_m    = 8'h00;
        last1    = 8'h00;
        last3    = 8'h00;
        sb1.delete();
        sb3.delete();
    endtask

    // Reference behaviour at one rising edge, applied to the inputs the DUTs are sampling.
    task automatic modelStep();
        exp_t e;
        if (!reset) return;
        if (locked_m && rd_req) begin
            e.fault = (rd_addr >= 8'd128);
            e.data  = e.fault ? 8'h00 : mem_m[rd_addr];
            e.due   = edge_cnt;
            sb1.push_back(e);
            e.due   = edge_cnt + 2;
            sb3.push_back(e);
        end
        if (!locked_m) begin
            if (load_we) begin
                if (load_addr < 8'd128) begin
                    mem_m[load_addr] = load_data;
                    sum_m = sum_m + load_data;
                end else begin
                    err_m = 1'b1;
                end
            end
            if (load_done) locked_m = 1'b1;
        end else if (load_we) begin
            err_m = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        edge_cnt++;
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] la, input logic [7:0] ld,
                                 input logic done, input logic req, input logic [7:0] ra);
        load_we   = we;
        load_addr = la;
        load_data = ld;
        load_done = done;
        rd_req    = req;
        rd_addr   = ra;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        reset = 1'b0;
        modelReset();
        load_we = 1'b0; load_done = 1'b0; rd_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [7:0] pickAddr();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(128, 255));
        return 8'($urandom_range(0, 127));
    endfunction

    // Monitor: pops the scoreboards whenever a DUT presents rd_valid and checks status outputs.
    always @(negedge clock) begin
        if (sb1.size() > 0 && sb1[0].due < edge_cnt) begin
            e1 = sb1.pop_front();
            checkOutput("lat1_missing_valid", edge_cnt, e1.due);
        end
        if (rd_valid1) begin
            if (sb1.size() == 0) begin
                checkOutput("lat1_unexpected_valid", rd_valid1, 1'b0);
            end else begin
                e1 = sb1.pop_front();
                checkOutput("lat1_latency", edge_cnt, e1.due);
                checkOutput("lat1_data", rd_data1, e1.data);
                checkOutput("lat1_fault", rd_fault1, e1.fault);
                last1 = e1.data;
            end
        end else begin
            checkOutput("lat1_fault_idle", rd_fault1, 1'b0);
            checkOutput("lat1_data_hold", rd_data1, last1);
        end

        if (sb3.size() > 0 && sb3[0].due < edge_cnt) begin
            e3 = sb3.pop_front();
            checkOutput("lat3_missing_valid", edge_cnt, e3.due);
        end
        if (rd_valid3) begin
            if (sb3.size() == 0) begin
                checkOutput("lat3_unexpected_valid", rd_valid3, 1'b0);
            end else begin
                e3 = sb3.pop_front();
                checkOutput("lat3_latency", edge_cnt, e3.due);
                checkOutput("lat3_data", rd_data3, e3.data);
                checkOutput("lat3_fault", rd_fault3, e3.fault);
                last3 = e3.data;
            end
        end else begin
            checkOutput("lat3_fault_idle", rd_fault3, 1'b0);
            checkOutput("lat3_data_hold", rd_data3, last3);
        end

        checkOutput("locked", {locked1, locked3}, {locked_m, locked_m});
        checkOutput("rd_ready", {rd_ready1, rd_ready3}, {locked_m, locked_m});
        checkOutput("load_err", {load_err1, load_err3}, {err_m, err_m});
        checkOutput("load_sum", {load_sum1, load_sum3}, {sum_m, sum_m});
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_cnt = 0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        mem_m[0] = 8'h86; mem_m[1] = 8'hAA; mem_m[2] = 8'h96;
        mem_m[3] = 8'hE0; mem_m[4] = 8'h20; mem_m[5] = 8'h00;
        reset = 1'b0;
        load_we = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        load_done = 1'b0; rd_req = 1'b0; rd_addr = 8'h00;
        modelReset();

        // Default program fetched back-to-back.
        doReset();
        checkOutput("reset_locked", locked1, 1'b0);
        checkOutput("reset_rd_data", rd_data1, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int a = 0; a < 6; a++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(a));
        idle(4);
        checkOutput("t1_sum", load_sum1, 8'h00);

        // Boot load with sum wrap.
        doReset();
        applyStimulus(1'b1, 8'd10, 8'h12, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'd11, 8'hF0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'd12, 8'h01, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd11);
        idle(3);
        checkOutput("t2_rd_data", rd_data1, 8'hF0);
        checkOutput("t2_sum", load_sum1, 8'h03);
        checkOutput("t2_err", load_err1, 1'b0);

        // Out-of-range boot write, then a write attempt while locked.
        doReset();
        applyStimulus(1'b1, 8'd200, 8'h5A, 1'b0, 1'b0, 8'h00);
        checkOutput("t3_err_boot", load_err1, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'd3, 8'h77, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd3);
        idle(3);
        checkOutput("t3_err_run", load_err1, 1'b1);
        checkOutput("t3_rd_data", rd_data1, 8'hE0);

        // Faulting fetches followed by a good one.
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd128);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd255);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd1);
        idle(4);
        checkOutput("t4_rd_data", rd_data3, 8'hAA);

        // Reset in the middle of the deep pipeline; memory must survive.
        doReset();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int a = 0; a < 3; a++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(a));
        idle(1);
        doReset();
        checkOutput("t5_locked", locked3, 1'b0);
        checkOutput("t5_ready", rd_ready3, 1'b0);
        idle(5);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        for (int a = 10; a < 13; a++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'(a));
        idle(4);

        // Requests dropped in BOOT; write and done in the same cycle.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd4);
        applyStimulus(1'b1, 8'd4, 8'h55, 1'b1, 1'b1, 8'd4);
        checkOutput("t6_locked", locked1, 1'b1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'd4);
        idle(4);
        checkOutput("t6_rd_data", rd_data3, 8'h55);

        // Randomised sessions; each reset lands while fetches are still in flight.
        for (int r = 0; r < 10; r++) begin
            doReset();
            for (int i = 0; i < 20; i++) begin
                applyStimulus(1'($urandom_range(0, 1)), pickAddr(), 8'($urandom),
                              1'(i > 5 && $urandom_range(0, 15) == 0),
                              1'($urandom_range(0, 1)), pickAddr());
            end
            if (!locked_m) applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
            for (int i = 0; i < 60; i++) begin
                applyStimulus(1'($urandom_range(0, 19) == 0), pickAddr(), 8'($urandom),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), pickAddr());
            end
        end
        idle(5);
        checkOutput("final_sb1_empty", sb1.size(), 0);
        checkOutput("final_sb3_empty", sb3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
